// File: rtl/load_store_unit_pkg.sv
// Shared CPU constants for the data-memory port: access size encodings,
// load/store unit state encodings and alignment helpers.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SINGLE = 2'b01,
    ST_SPLIT  = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_WORD) && (addr_lo != 2'b00)) ||
           ((size == SIZE_HALF) && addr_lo[0]);
  endfunction

  // Index of the final byte when a half/word is split into byte accesses.
  function automatic logic [1:0] last_byte_index(input logic [1:0] size);
    return (size == SIZE_WORD) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel plus data-memory bus of the load/store unit.
// slave = the unit itself, master = execute stage and memory around it.
interface load_store_unit_if #(parameter int DATA_WIDTH = 32);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_sign_ext;
  logic [DATA_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;

  logic                  memory_enable_write;
  logic                  memory_enable_read;
  logic [1:0]            memory_size;
  logic                  memory_sign_ext;
  logic [DATA_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0] memory_data_to_write;
  logic [DATA_WIDTH-1:0] memory_data_read;
  logic                  misaligned_exception;

  modport slave (
    input  req_valid, req_write, req_size, req_sign_ext, req_address, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    input  resp_ready,
    output memory_enable_write, memory_enable_read, memory_size, memory_sign_ext,
    output memory_address, memory_data_to_write,
    input  memory_data_read, misaligned_exception
  );

  modport master (
    output req_valid, req_write, req_size, req_sign_ext, req_address, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    output resp_ready,
    input  memory_enable_write, memory_enable_read, memory_size, memory_sign_ext,
    input  memory_address, memory_data_to_write,
    output memory_data_read, misaligned_exception
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Byte/half sign or zero extension of load data; words pass through.
// Shared with the writeback path.
module load_extend
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = data;
    case (size)
      SIZE_BYTE: result = {{(DATA_WIDTH-8){sign_ext & data[7]}}, data[7:0]};
      SIZE_HALF: result = {{(DATA_WIDTH-16){sign_ext & data[15]}}, data[15:0]};
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, optional splitting of
// misaligned half/word accesses into little-endian byte accesses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a request; rejects illegal/unsupported accesses
//   ST_SINGLE | one aligned memory access, load data captured at the edge
//   ST_SPLIT  | byte i of a misaligned access, i = 0..N-1
//   ST_RESP   | response held until resp_ready
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_t            state;
  lsu_state_t            state_next;
  logic                  write_q;
  logic                  sign_ext_q;
  logic [1:0]            size_q;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_acc;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_error_q;
  logic [DATA_WIDTH-1:0] assembled;
  logic [DATA_WIDTH-1:0] ext_in;
  logic [DATA_WIDTH-1:0] ext_out;
  logic                  req_misaligned;
  logic                  req_reject;
  logic                  last_byte;

  assign req_misaligned = is_misaligned(bus.req_size, bus.req_address[1:0]);
  assign req_reject     = (bus.req_size == SIZE_ILLEGAL) ||
                          (req_misaligned && !ALLOW_MISALIGNED);
  assign last_byte      = (byte_idx == last_byte_index(size_q));

  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_reject)          state_next = ST_RESP;
          else if (req_misaligned) state_next = ST_SPLIT;
          else                     state_next = ST_SINGLE;
        end
      end
      ST_SINGLE: state_next = ST_RESP;
      ST_SPLIT:  if (last_byte) state_next = ST_RESP;
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.memory_enable_write  = 1'b0;
    bus.memory_enable_read   = 1'b0;
    bus.memory_size          = 2'b00;
    bus.memory_sign_ext      = 1'b0;
    bus.memory_address       = '0;
    bus.memory_data_to_write = '0;
    case (state)
      ST_SINGLE: begin
        bus.memory_enable_write  = write_q;
        bus.memory_enable_read   = !write_q;
        bus.memory_size          = size_q;
        bus.memory_sign_ext      = sign_ext_q;
        bus.memory_address       = address_q;
        bus.memory_data_to_write = wdata_q;
      end
      ST_SPLIT: begin
        bus.memory_enable_write  = write_q;
        bus.memory_enable_read   = !write_q;
        bus.memory_size          = SIZE_BYTE;
        bus.memory_address       = address_q + DATA_WIDTH'(byte_idx);
        bus.memory_data_to_write = DATA_WIDTH'(wdata_q[{byte_idx, 3'b000} +: 8]);
      end
      default: ;
    endcase
  end

  // Split loads merge the byte arriving this cycle so the final byte can be
  // extended and registered in the same edge that leaves SPLIT.
  always_comb begin
    assembled = rdata_acc;
    assembled[{byte_idx, 3'b000} +: 8] = bus.memory_data_read[7:0];
  end

  assign ext_in = (state == ST_SPLIT) ? assembled : bus.memory_data_read;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .data     (ext_in),
    .size     (size_q),
    .sign_ext (sign_ext_q),
    .result   (ext_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      write_q      <= 1'b0;
      sign_ext_q   <= 1'b0;
      size_q       <= 2'b00;
      byte_idx     <= 2'd0;
      address_q    <= '0;
      wdata_q      <= '0;
      rdata_acc    <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            write_q      <= bus.req_write;
            sign_ext_q   <= bus.req_sign_ext;
            size_q       <= bus.req_size;
            address_q    <= bus.req_address;
            wdata_q      <= bus.req_wdata;
            byte_idx     <= 2'd0;
            rdata_acc    <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= req_reject;
          end
        end
        ST_SINGLE: begin
          if (!write_q) resp_rdata_q <= ext_out;
          if (bus.misaligned_exception) resp_error_q <= 1'b1;
        end
        ST_SPLIT: begin
          byte_idx <= byte_idx + 2'd1;
          if (!write_q) begin
            rdata_acc <= assembled;
            if (last_byte) resp_rdata_q <= ext_out;
          end
          if (bus.misaligned_exception) resp_error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory model, one DUT with
// misaligned splitting and one that rejects misaligned accesses.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clear;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(32)) bus ();
  load_store_unit_if #(.DATA_WIDTH(32)) bus0 ();

  load_store_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  load_store_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // Memory model: 256 bytes indexed by address[7:0], so 0xFFFFFFFF wraps to 0.
  logic [7:0]  mem [256];
  logic [7:0]  ma, mb0, mb1, mb2, mb3;
  logic [31:0] rdv;

  assign ma  = bus.memory_address[7:0];
  assign mb0 = mem[ma];
  assign mb1 = mem[ma + 8'd1];
  assign mb2 = mem[ma + 8'd2];
  assign mb3 = mem[ma + 8'd3];

  always_comb begin
    case (bus.memory_size)
      2'b00:   rdv = {{24{bus.memory_sign_ext & mb0[7]}}, mb0};
      2'b01:   rdv = {{16{bus.memory_sign_ext & mb1[7]}}, mb1, mb0};
      default: rdv = {mb3, mb2, mb1, mb0};
    endcase
  end

  assign bus.memory_data_read = bus.memory_enable_read ? rdv : 32'h0;
  assign bus.misaligned_exception = (bus.memory_enable_read | bus.memory_enable_write) &&
    (((bus.memory_size == 2'b10) && (bus.memory_address[1:0] != 2'b00)) ||
     ((bus.memory_size == 2'b01) && bus.memory_address[0]));

  assign bus0.memory_data_read     = 32'h0;
  assign bus0.misaligned_exception = 1'b0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.memory_enable_write) begin
      case (bus.memory_size)
        2'b00: mem[ma] <= bus.memory_data_to_write[7:0];
        2'b01: begin
          mem[ma]        <= bus.memory_data_to_write[7:0];
          mem[ma + 8'd1] <= bus.memory_data_to_write[15:8];
        end
        2'b10: begin
          mem[ma]        <= bus.memory_data_to_write[7:0];
          mem[ma + 8'd1] <= bus.memory_data_to_write[15:8];
          mem[ma + 8'd2] <= bus.memory_data_to_write[23:16];
          mem[ma + 8'd3] <= bus.memory_data_to_write[31:24];
        end
        default: ;
      endcase
    end
  end

  // Access monitor, sampled mid-cycle.
  int          rd_cnt, wr_cnt, both_cnt, exc_cnt, en0_cnt;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] wd_log[$];

  always @(negedge clk) begin
    if (bus.memory_enable_read) begin
      rd_cnt++;
      rd_log.push_back(bus.memory_address);
    end
    if (bus.memory_enable_write) begin
      wr_cnt++;
      wr_log.push_back(bus.memory_address);
      wd_log.push_back(bus.memory_data_to_write);
    end
    if (bus.memory_enable_read && bus.memory_enable_write) both_cnt++;
    if (bus.misaligned_exception) exc_cnt++;
    if (bus0.memory_enable_read || bus0.memory_enable_write) en0_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_cnt = 0; wr_cnt = 0;
    rd_log.delete(); wr_log.delete(); wd_log.delete();
  endtask

  // Returns latency in cycles after the request handshake edge.
  task automatic send(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_sign_ext = sx;
    bus.req_address  = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_error;
    if (bus.resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;

    rst_n = 1'b0;
    mem_clear = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_sign_ext = 1'b0; bus.req_address = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'b00;
    bus0.req_sign_ext = 1'b0; bus0.req_address = '0; bus0.req_wdata = '0;
    bus0.resp_ready = 1'b1;
    both_cnt = 0; exc_cnt = 0; en0_cnt = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_clear = 1'b0;

    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst_mem_en", {30'd0, bus.memory_enable_write, bus.memory_enable_read}, 32'd0);
    chk("rst_mem_addr", bus.memory_address, 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Aligned store then load
    clear_logs();
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("sw_lat", lat, 32'd2);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_error", 32'(er), 32'd0);
    chk("sw_pulses", wr_cnt * 16 + rd_cnt, 32'd16);
    chk("sw_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

    clear_logs();
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("lw_lat", lat, 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_pulses", wr_cnt * 16 + rd_cnt, 32'd1);

    send(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, er);
    chk("lh_aligned", rd, 32'hFFFFBEEF);

    // Misaligned word load
    send(1'b1, 2'b10, 1'b0, 32'h0, 32'h44332211, lat, rd, er);
    send(1'b1, 2'b10, 1'b0, 32'h4, 32'h88776655, lat, rd, er);
    clear_logs();
    exc_cnt = 0;
    send(1'b0, 2'b10, 1'b0, 32'h1, 32'h0, lat, rd, er);
    chk("lw_mis_lat", lat, 32'd5);
    chk("lw_mis_rdata", rd, 32'h55443322);
    chk("lw_mis_error", 32'(er), 32'd0);
    chk("lw_mis_nreads", rd_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) chk("lw_mis_addr", rd_log[i], 32'(1 + i));
    end
    chk("lw_mis_exc", exc_cnt, 32'd0);

    // Misaligned half loads, signed and unsigned
    send(1'b1, 2'b00, 1'b0, 32'h6, 32'h80, lat, rd, er);
    send(1'b1, 2'b00, 1'b0, 32'h7, 32'hF0, lat, rd, er);
    send(1'b1, 2'b00, 1'b0, 32'h8, 32'h9A, lat, rd, er);
    chk("sb_lat", lat, 32'd2);
    send(1'b0, 2'b01, 1'b1, 32'h7, 32'h0, lat, rd, er);
    chk("lh_mis_lat", lat, 32'd3);
    chk("lh_mis_rdata", rd, 32'hFFFF9AF0);
    send(1'b0, 2'b01, 1'b0, 32'h7, 32'h0, lat, rd, er);
    chk("lhu_mis_rdata", rd, 32'h00009AF0);

    // Misaligned word store and read back
    clear_logs();
    send(1'b1, 2'b10, 1'b0, 32'h3, 32'hAABBCCDD, lat, rd, er);
    chk("sw_mis_lat", lat, 32'd5);
    chk("sw_mis_rdata", rd, 32'h0);
    chk("sw_mis_nwrites", wr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_log.size()) begin
        chk("sw_mis_addr", wr_log[i], 32'(3 + i));
        chk("sw_mis_data", wd_log[i], (32'hAABBCCDD >> (8 * i)) & 32'hFF);
      end
    end
    chk("sw_mis_mem", {mem[8'h6], mem[8'h5], mem[8'h4], mem[8'h3]}, 32'hAABBCCDD);
    send(1'b0, 2'b10, 1'b0, 32'h3, 32'h0, lat, rd, er);
    chk("lw_back_rdata", rd, 32'hAABBCCDD);

    send(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, lat, rd, er);
    chk("lb_signed", rd, 32'hFFFFFFBB);

    // Illegal size
    clear_logs();
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("illegal_lat", lat, 32'd1);
    chk("illegal_error", 32'(er), 32'd1);
    chk("illegal_rdata", rd, 32'h0);
    chk("illegal_pulses", rd_cnt + wr_cnt, 32'd0);

    // Address wrap on a split half
    send(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h12, lat, rd, er);
    clear_logs();
    send(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er);
    chk("wrap_rdata", rd, 32'h00001112);
    chk("wrap_nreads", rd_log.size(), 32'd2);
    if (rd_log.size() == 2) chk("wrap_addr1", rd_log[1], 32'h0);

    // Backpressure
    bus.resp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("bp_lat", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata", bus.resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);

    // Reset during split store after byte 1
    clear_logs();
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_sign_ext = 1'b0;
    bus.req_address = 32'h21; bus.req_wdata = 32'h11223344; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstsplit_en", {30'd0, bus.memory_enable_write, bus.memory_enable_read}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rstsplit_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("rstsplit_ready", 32'(bus.req_ready), 32'd1);
    chk("rstsplit_nwrites", wr_cnt, 32'd2);
    chk("rstsplit_mem", {mem[8'h24], mem[8'h23], mem[8'h22], mem[8'h21]}, 32'h00003344);

    // Misaligned rejected when splitting is disabled
    en0_cnt = 0;
    @(negedge clk);
    bus0.req_write = 1'b0; bus0.req_size = 2'b10; bus0.req_address = 32'h2;
    bus0.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    chk("nomis_valid_c1", 32'(bus0.resp_valid), 32'd1);
    chk("nomis_error", 32'(bus0.resp_error), 32'd1);
    chk("nomis_rdata", bus0.resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("nomis_done", 32'(bus0.resp_valid), 32'd0);
    chk("nomis_pulses", en0_cnt, 32'd0);

    chk("both_enables", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
